wb_commit_stage: RTL

Parametrised successor to the current writeback stage. It accepts one instruction per handshake from the MEM stage and tolerates a configurable CSR read latency by stalling. It commits register, CSR and exception/ertn effects in exactly one cycle, and keeps a retired-instruction counter. It sits between the MEM stage, the ID stage (forwarding/stall), the CSR file and the IF stage (redirect).

---
 rtl/wb_commit_stage_pkg.sv | 37 +++
 rtl/wb_ex_encoder.sv | 20 ++
 rtl/wb_commit_stage.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/wb_commit_stage_pkg.sv
// Shared types and constants for the writeback/commit stage.
// Exception codes, fixed CSR numbers, ex_vec bit positions and FSM states.
package wb_commit_stage_pkg;

  localparam int unsigned EX_W      = 6;
  localparam int unsigned ECODE_W   = 6;
  localparam int unsigned ESUB_W    = 9;
  localparam int unsigned LAT_CNT_W = 2;

  localparam logic [ECODE_W-1:0] ECODE_INT  = 6'h00;
  localparam logic [ECODE_W-1:0] ECODE_ADEF = 6'h08;
  localparam logic [ECODE_W-1:0] ECODE_SYS  = 6'h0B;
  localparam logic [ECODE_W-1:0] ECODE_BRK  = 6'h0C;
  localparam logic [ECODE_W-1:0] ECODE_INE  = 6'h0D;
  localparam logic [ECODE_W-1:0] ECODE_ALE  = 6'h09;

  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_TID    = 14'h040;

  // ex_vec layout is {INT,ADEF,SYSCALL,BRK,INE,ALE}
  typedef enum int unsigned {
    EX_ALE  = 0,
    EX_INE  = 1,
    EX_BRK  = 2,
    EX_SYS  = 3,
    EX_ADEF = 4,
    EX_INT  = 5
  } ex_idx_e;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_CSR_WAIT = 2'd1,
    ST_COMMIT   = 2'd2
  } state_e;

endpackage

// File: rtl/wb_ex_encoder.sv
// Priority encoder from the exception vector to the architectural ecode.
module wb_ex_encoder
  import wb_commit_stage_pkg::*;
(
  input  logic [EX_W-1:0]    ex_vec,
  output logic [ECODE_W-1:0] ecode_c
);

  // Highest-priority source wins; an empty vector reports ECODE_INT.
  always_comb begin
    ecode_c = ECODE_INT;
    if (ex_vec[EX_INT])       ecode_c = ECODE_INT;
    else if (ex_vec[EX_ADEF]) ecode_c = ECODE_ADEF;
    else if (ex_vec[EX_SYS])  ecode_c = ECODE_SYS;
    else if (ex_vec[EX_BRK])  ecode_c = ECODE_BRK;
    else if (ex_vec[EX_INE])  ecode_c = ECODE_INE;
    else if (ex_vec[EX_ALE])  ecode_c = ECODE_ALE;
  end

endmodule

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: holds one instruction, waits out CSR read latency,
// then commits GPR, CSR and exception/ertn effects in a single cycle.
module wb_commit_stage
  import wb_commit_stage_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned CSR_NUM_W  = 14,
  parameter int unsigned CSR_RD_LAT = 1,
  parameter int unsigned CNT_W      = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 mem_to_wb_valid,
  output logic                 wb_allowin,
  input  logic                 in_rf_we,
  input  logic [REG_AW-1:0]    in_rf_waddr,
  input  logic [DATA_W-1:0]    in_rf_wdata,
  input  logic [DATA_W-1:0]    in_pc,
  input  logic                 in_csr_re,
  input  logic                 in_csr_we,
  input  logic                 in_read_tid,
  input  logic                 in_ertn,
  input  logic [CSR_NUM_W-1:0] in_csr_num,
  input  logic [DATA_W-1:0]    in_csr_wmask,
  input  logic [DATA_W-1:0]    in_csr_wvalue,
  input  logic [EX_W-1:0]      in_ex_vec,
  input  logic [ESUB_W-1:0]    in_esubcode,
  input  logic [DATA_W-1:0]    in_vaddr,
  output logic                 csr_re,
  output logic [CSR_NUM_W-1:0] csr_num,
  input  logic [DATA_W-1:0]    csr_rvalue,
  output logic                 csr_we,
  output logic [DATA_W-1:0]    csr_wmask,
  output logic [DATA_W-1:0]    csr_wvalue,
  output logic                 fwd_we,
  output logic [REG_AW-1:0]    fwd_waddr,
  output logic [DATA_W-1:0]    fwd_wdata,
  output logic                 fwd_busy,
  output logic                 wb_ex,
  output logic [ECODE_W-1:0]   wb_ecode,
  output logic [ESUB_W-1:0]    wb_esubcode,
  output logic [DATA_W-1:0]    wb_ex_pc,
  output logic [DATA_W-1:0]    wb_vaddr,
  output logic                 ertn_flush,
  output logic [DATA_W-1:0]    wb_redirect_pc,
  output logic [DATA_W-1:0]    debug_wb_pc,
  output logic [3:0]           debug_wb_rf_we,
  output logic [REG_AW-1:0]    debug_wb_rf_wnum,
  output logic [DATA_W-1:0]    debug_wb_rf_wdata,
  output logic [CNT_W-1:0]     retire_cnt
);

  state_e                 state, state_d;
  logic [LAT_CNT_W-1:0]   lat_cnt, lat_cnt_d;
  logic                   rdata_capture;

  logic                   rf_we_q, csr_re_q, csr_we_q, read_tid_q, ertn_q;
  logic [REG_AW-1:0]      rf_waddr_q;
  logic [DATA_W-1:0]      rf_wdata_q, pc_q, csr_wmask_q, csr_wvalue_q, vaddr_q, rdata_q;
  logic [CSR_NUM_W-1:0]   csr_num_q;
  logic [EX_W-1:0]        ex_vec_q;
  logic [ESUB_W-1:0]      esubcode_q;

  logic ex_any, read_req_q, in_read_req, commit, accept;
  logic [DATA_W-1:0] csr_data, final_wdata;

  assign ex_any      = |ex_vec_q;
  assign read_req_q  = csr_re_q | read_tid_q | ex_any | ertn_q;
  assign in_read_req = in_csr_re | in_read_tid | (|in_ex_vec) | in_ertn;
  assign commit      = (state == ST_COMMIT);
  assign wb_allowin  = (state == ST_EMPTY) | (commit & ~ex_any & ~ertn_q);
  assign accept      = mem_to_wb_valid & wb_allowin;

  // Zero latency means the CSR file answers in the same cycle as the request.
  assign csr_data    = (CSR_RD_LAT == 0) ? csr_rvalue : rdata_q;
  assign final_wdata = (csr_re_q | read_tid_q) ? csr_data : rf_wdata_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_EMPTY;
      lat_cnt <= '0;
    end else begin
      state   <= state_d;
      lat_cnt <= lat_cnt_d;
    end
  end

  always_comb begin
    state_d       = state;
    lat_cnt_d     = lat_cnt;
    rdata_capture = 1'b0;
    case (state)
      ST_EMPTY, ST_COMMIT: begin
        if (accept) begin
          if (in_read_req && (CSR_RD_LAT != 0)) begin
            state_d   = ST_CSR_WAIT;
            lat_cnt_d = LAT_CNT_W'(CSR_RD_LAT - 1);
          end else begin
            state_d = ST_COMMIT;
          end
        end else if (state == ST_COMMIT) begin
          state_d = ST_EMPTY;
        end
      end
      ST_CSR_WAIT: begin
        if (lat_cnt == '0) begin
          state_d       = ST_COMMIT;
          rdata_capture = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt - LAT_CNT_W'(1);
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Payload capture on accept; CSR data sampled when the latency counter expires.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      pc_q         <= '0;
      csr_re_q     <= 1'b0;
      csr_we_q     <= 1'b0;
      read_tid_q   <= 1'b0;
      ertn_q       <= 1'b0;
      csr_num_q    <= '0;
      csr_wmask_q  <= '0;
      csr_wvalue_q <= '0;
      ex_vec_q     <= '0;
      esubcode_q   <= '0;
      vaddr_q      <= '0;
      rdata_q      <= '0;
    end else begin
      if (accept) begin
        rf_we_q      <= in_rf_we;
        rf_waddr_q   <= in_rf_waddr;
        rf_wdata_q   <= in_rf_wdata;
        pc_q         <= in_pc;
        csr_re_q     <= in_csr_re;
        csr_we_q     <= in_csr_we;
        read_tid_q   <= in_read_tid;
        ertn_q       <= in_ertn;
        csr_num_q    <= in_csr_num;
        csr_wmask_q  <= in_csr_wmask;
        csr_wvalue_q <= in_csr_wvalue;
        ex_vec_q     <= in_ex_vec;
        esubcode_q   <= in_esubcode;
        vaddr_q      <= in_vaddr;
      end
      if (rdata_capture) rdata_q <= csr_rvalue;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               retire_cnt <= '0;
    else if (commit && !ex_any) retire_cnt <= retire_cnt + CNT_W'(1);
  end

  // Exceptions and ertn override the instruction's own CSR number.
  always_comb begin
    csr_num = csr_num_q;
    if (ex_any)          csr_num = CSR_NUM_W'(CSR_EENTRY);
    else if (ertn_q)     csr_num = CSR_NUM_W'(CSR_ERA);
    else if (read_tid_q) csr_num = CSR_NUM_W'(CSR_TID);
  end

  assign csr_re     = (state != ST_EMPTY) & read_req_q;
  assign csr_we     = commit & csr_we_q & ~ex_any;
  assign csr_wmask  = csr_wmask_q;
  assign csr_wvalue = csr_wvalue_q;

  assign fwd_we    = (state != ST_EMPTY) & rf_we_q & ~ex_any;
  assign fwd_waddr = rf_waddr_q;
  assign fwd_wdata = final_wdata;
  assign fwd_busy  = fwd_we & (csr_re_q | read_tid_q) & (state == ST_CSR_WAIT);

  assign wb_ex          = commit & ex_any;
  assign ertn_flush     = commit & ertn_q & ~ex_any;
  assign wb_esubcode    = esubcode_q;
  assign wb_ex_pc       = pc_q;
  assign wb_vaddr       = vaddr_q;
  assign wb_redirect_pc = csr_data;

  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_we    = {4{commit & rf_we_q & ~ex_any}};
  assign debug_wb_rf_wnum  = rf_waddr_q;
  assign debug_wb_rf_wdata = final_wdata;

  wb_ex_encoder u_ex_encoder (
    .ex_vec  (ex_vec_q),
    .ecode_c (wb_ecode)
  );

endmodule
